// File: rtl/sensor_cmd_tx_pkg.sv
// Shared definitions for the sensor command transmitter: frame header,
// frame length, command record and the state encodings of both FSMs.
package sensor_cmd_tx_pkg;

  localparam logic [7:0] HDR0      = 8'hFF;
  localparam logic [7:0] HDR1      = 8'hAA;
  localparam int         FRAME_LEN = 5;

  typedef struct packed {
    logic [7:0]  reg_addr;
    logic [15:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } bit_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_GAP
  } seq_state_t;

  // Byte at position idx of the frame: header, register, data low, data high.
  function automatic logic [7:0] frame_byte(cmd_t cmd, logic [2:0] idx);
    case (idx)
      3'd0:    return HDR0;
      3'd1:    return HDR1;
      3'd2:    return cmd.reg_addr;
      3'd3:    return cmd.data[7:0];
      default: return cmd.data[15:8];
    endcase
  endfunction

endpackage

// File: rtl/sensor_cmd_tx_uart.sv
// 8N1 byte serialiser. A start request during the final stop-bit cycle
// chains straight into the next start bit so bytes go out back-to-back.
module uart_byte_tx
  import sensor_cmd_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk_uart,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  bit_state_t  state_q, state_d;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  byte_q;
  logic        bit_end;

  assign bit_end = (clk_cnt_q == 16'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_uart or negedge reset_n) begin
    if (!reset_n) state_q <= TX_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (start) state_d = TX_START;
      TX_START: if (bit_end) state_d = TX_DATA;
      TX_DATA:  if (bit_end && bit_idx_q == 3'd7) state_d = TX_STOP;
      TX_STOP:  if (bit_end) state_d = start ? TX_START : TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == TX_STOP) && bit_end;
  end

  // The line value is computed from the next state so tx stays a plain flop.
  always_ff @(posedge clk_uart or negedge reset_n) begin
    if (!reset_n) begin
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      tx        <= 1'b1;
    end else begin
      if (state_q == TX_IDLE || bit_end) clk_cnt_q <= '0;
      else                               clk_cnt_q <= clk_cnt_q + 16'd1;

      if (state_d == TX_START && state_q != TX_START) byte_q <= data;

      if (state_q == TX_DATA && bit_end) bit_idx_q <= bit_idx_q + 3'd1;

      case (state_d)
        TX_START: tx <= 1'b0;
        TX_DATA:  tx <= byte_q[(state_q == TX_DATA && bit_end) ? bit_idx_q + 3'd1 : bit_idx_q];
        default:  tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/sensor_cmd_tx.sv
// Frames a sensor register write (FF AA reg lo hi) onto the serial line
// toward the wireless module, followed by an idle gap.
module sensor_cmd_tx
  import sensor_cmd_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int GAP_BITS     = 10
) (
  input  logic        clk_uart,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_reg,
  input  logic [15:0] cmd_data,
  output logic        wireless_rx,
  output logic        busy
);

  seq_state_t  state_q, state_d;
  logic        ready_en_q;
  cmd_t        cmd_q;
  logic [2:0]  byte_idx_q;
  logic [15:0] gap_clk_q;
  logic [7:0]  gap_bit_q;
  logic        accept;
  logic        last_byte;
  logic        gap_bit_end;
  logic        gap_end;
  logic        tx_start;
  logic        tx_done;
  logic [7:0]  tx_byte;

  // ready_en_q holds off acceptance until the first edge after reset.
  assign cmd_ready   = ready_en_q && (state_q == SEQ_IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign last_byte   = (byte_idx_q == 3'(FRAME_LEN - 1));
  assign gap_bit_end = (gap_clk_q == 16'(CLKS_PER_BIT - 1));
  assign gap_end     = gap_bit_end && (gap_bit_q == 8'(GAP_BITS - 1));

  always_ff @(posedge clk_uart or negedge reset_n) begin
    if (!reset_n) state_q <= SEQ_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: if (accept) state_d = SEQ_SEND;
      SEQ_SEND: if (tx_done && last_byte) state_d = (GAP_BITS == 0) ? SEQ_IDLE : SEQ_GAP;
      SEQ_GAP:  if (gap_end) state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  always_comb begin
    busy     = ready_en_q && (state_q != SEQ_IDLE);
    tx_start = accept || (state_q == SEQ_SEND && tx_done && !last_byte);
    tx_byte  = accept ? HDR0 : frame_byte(cmd_q, byte_idx_q + 3'd1);
  end

  always_ff @(posedge clk_uart or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q <= 1'b0;
      cmd_q      <= '0;
      byte_idx_q <= '0;
      gap_clk_q  <= '0;
      gap_bit_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;

      if (accept) begin
        cmd_q      <= '{reg_addr: cmd_reg, data: cmd_data};
        byte_idx_q <= '0;
      end else if (state_q == SEQ_SEND && tx_done && !last_byte) begin
        byte_idx_q <= byte_idx_q + 3'd1;
      end

      if (state_q != SEQ_GAP) begin
        gap_clk_q <= '0;
        gap_bit_q <= '0;
      end else if (gap_bit_end) begin
        gap_clk_q <= '0;
        gap_bit_q <= gap_bit_q + 8'd1;
      end else begin
        gap_clk_q <= gap_clk_q + 16'd1;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_uart(clk_uart),
    .reset_n (reset_n),
    .start   (tx_start),
    .data    (tx_byte),
    .done    (tx_done),
    .tx      (wireless_rx)
  );

endmodule

// File: tb/tb_sensor_cmd_tx.sv
// Self-checking bench for sensor_cmd_tx: one instance with a 2-bit gap and
// one with no gap, both checked against a cycle-level line model.
module tb_sensor_cmd_tx;

  localparam int CPB   = 4;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;

  logic        clk_uart = 1'b0;
  logic        reset_n  = 1'b0;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [1:0]  rx;
  logic [1:0]  busy;
  logic [7:0]  reg_in  [2];
  logic [15:0] data_in [2];

  int tests = 0;
  int fails = 0;

  always #5 clk_uart = ~clk_uart;

  sensor_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP_A)) dut_gap (
    .clk_uart   (clk_uart),
    .reset_n    (reset_n),
    .cmd_valid  (valid[0]),
    .cmd_ready  (ready[0]),
    .cmd_reg    (reg_in[0]),
    .cmd_data   (data_in[0]),
    .wireless_rx(rx[0]),
    .busy       (busy[0])
  );

  sensor_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP_B)) dut_nogap (
    .clk_uart   (clk_uart),
    .reset_n    (reset_n),
    .cmd_valid  (valid[1]),
    .cmd_ready  (ready[1]),
    .cmd_reg    (reg_in[1]),
    .cmd_data   (data_in[1]),
    .wireless_rx(rx[1]),
    .busy       (busy[1])
  );

  // Line level k cycles after acceptance: 5 bytes of 10 bits, then idle high.
  function automatic logic exp_line(logic [7:0] r, logic [15:0] dat, int k);
    logic [7:0] bytes [5];
    int bitpos, b, j;
    bytes  = '{8'hFF, 8'hAA, r, dat[7:0], dat[15:8]};
    if (k >= 50 * CPB) return 1'b1;
    bitpos = k / CPB;
    b      = bitpos / 10;
    j      = bitpos % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return bytes[b][j-1];
  endfunction

  // Called at a falling edge; returns at the falling edge just after the gap.
  task automatic run_frame(input int d, input logic [7:0] r, input logic [15:0] dat,
                           input bit scramble, input bit hold, output int waited);
    int         gap;
    int         n;
    int         busy_cnt;
    int         first_bad;
    logic       want;
    logic       samples [$];
    logic [7:0] bytes [5];
    logic [7:0] got;
    gap        = (d == 0) ? GAP_A : GAP_B;
    n          = (50 + gap) * CPB;
    bytes      = '{8'hFF, 8'hAA, r, dat[7:0], dat[15:8]};
    valid[d]   = 1'b1;
    reg_in[d]  = r;
    data_in[d] = dat;
    waited     = 0;
    while (!ready[d] && waited < 500) begin
      @(negedge clk_uart);
      waited++;
    end
    tests++;
    if (ready[d] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL accept_timeout d=%0d ready=%b after %0d cycles, want 1", d, ready[d], waited);
      valid[d] = 1'b0;
      return;
    end
    tests++;
    if (rx[d] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pre_accept_line d=%0d got %b want 1", d, rx[d]);
    end
    busy_cnt  = 0;
    first_bad = -1;
    want      = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_uart);
      if (k == 0 && !hold) valid[d] = 1'b0;
      samples.push_back(rx[d]);
      if (rx[d] !== exp_line(r, dat, k) && first_bad < 0) begin
        first_bad = k;
        want      = exp_line(r, dat, k);
      end
      if (busy[d] === 1'b1) busy_cnt++;
      if (scramble) begin
        reg_in[d]  = 8'($urandom);
        data_in[d] = 16'($urandom);
      end
    end
    tests++;
    if (first_bad >= 0) begin
      fails++;
      $display("[TB] FAIL line_wave d=%0d first bad cycle %0d got %b want %b",
               d, first_bad, samples[first_bad], want);
    end
    tests++;
    if (busy_cnt != n) begin
      fails++;
      $display("[TB] FAIL busy_len d=%0d got %0d cycles want %0d", d, busy_cnt, n);
    end
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 8; j++) got[j] = samples[(b * 10 + 1 + j) * CPB + CPB / 2];
      tests++;
      if (got !== bytes[b]) begin
        fails++;
        $display("[TB] FAIL byte_decode d=%0d byte %0d got %h want %h", d, b, got, bytes[b]);
      end
    end
    @(negedge clk_uart);
    tests++;
    if (ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ready_after d=%0d ready=%b busy=%b want ready=1 busy=0", d, ready[d], busy[d]);
    end
  endtask

  task automatic test_reset();
    int w;
    valid = 2'b00;
    for (int d = 0; d < 2; d++) begin
      reg_in[d]  = 8'h00;
      data_in[d] = 16'h0000;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk_uart);
    tests++;
    if (rx !== 2'b11 || busy !== 2'b00 || ready !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_state rx=%b busy=%b ready=%b want rx=11 busy=00 ready=00", rx, busy, ready);
    end
    reset_n = 1'b1;
    @(negedge clk_uart);
    tests++;
    if (ready !== 2'b11 || busy !== 2'b00) begin
      fails++;
      $display("[TB] FAIL ready_after_reset ready=%b busy=%b want ready=11 busy=00", ready, busy);
    end
    w = 0;
  endtask

  task automatic test_first_frame();
    int w;
    run_frame(0, 8'h01, 16'h0000, 1'b0, 1'b0, w);
    run_frame(1, 8'h01, 16'h0000, 1'b0, 1'b0, w);
  endtask

  task automatic test_bit_order();
    int w;
    run_frame(0, 8'h3C, 16'hA55A, 1'b0, 1'b0, w);
    run_frame(1, 8'hC3, 16'hA55A, 1'b0, 1'b0, w);
  endtask

  task automatic test_back_to_back(input int d);
    int w;
    run_frame(d, 8'($urandom), 16'($urandom), 1'b0, 1'b1, w);
    run_frame(d, 8'($urandom), 16'($urandom), 1'b0, 1'b1, w);
    tests++;
    if (w != 0) begin
      fails++;
      $display("[TB] FAIL back_to_back_start d=%0d waited %0d cycles want 0", d, w);
    end
    run_frame(d, 8'($urandom), 16'($urandom), 1'b0, 1'b0, w);
    tests++;
    if (w != 0) begin
      fails++;
      $display("[TB] FAIL back_to_back_start3 d=%0d waited %0d cycles want 0", d, w);
    end
  endtask

  task automatic test_scramble();
    int w;
    run_frame(0, 8'($urandom), 16'($urandom), 1'b1, 1'b0, w);
    run_frame(1, 8'($urandom), 16'($urandom), 1'b1, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(4)) @(negedge clk_uart);
      run_frame(i % 2, 8'($urandom), 16'($urandom), 1'b0, 1'b0, w);
    end
  endtask

  task automatic test_reset_midframe();
    int waited;
    int bad;
    int w;
    valid[0]   = 1'b1;
    reg_in[0]  = 8'h00;
    data_in[0] = 16'h0000;
    waited     = 0;
    while (!ready[0] && waited < 500) begin
      @(negedge clk_uart);
      waited++;
    end
    tests++;
    if (ready[0] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midreset_accept ready=%b want 1", ready[0]);
    end
    // Land inside the third byte (register byte, all zeros so the line is low).
    repeat (25 * CPB) begin
      @(negedge clk_uart);
      valid[0] = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (rx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_async rx=%b busy=%b ready=%b want rx=1 busy=0 ready=0",
               rx[0], busy[0], ready[0]);
    end
    repeat (2) @(negedge clk_uart);
    reset_n = 1'b1;
    bad     = 0;
    repeat (60 * CPB) begin
      @(negedge clk_uart);
      if (rx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL midreset_quiet %0d cycles with line low or busy, want 0", bad);
    end
    run_frame(0, 8'h5E, 16'h1234, 1'b0, 1'b0, w);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_bit_order();
    test_back_to_back(0);
    test_back_to_back(1);
    test_scramble();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
